// File: rtl/gb_frame_capture.sv
// gb_frame_capture: packs the 2-bit DMG pixel stream four pixels per byte and
// writes the 160x144 frame into a byte-wide framebuffer. A small FIFO
// decouples pixel arrival from framebuffer wait states.
//
// state   | meaning
// S_IDLE  | no write in flight, waiting for the FIFO to hold an entry
// S_WRITE | FB_WR asserted, FB_ADDR/FB_DATA held until the memory accepts
module gb_frame_capture #(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 144,
  parameter int ADDR_W     = 13,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PX_VALID,
  input  logic [1:0]        LD,
  input  logic              VSYNC,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [7:0]        FB_DATA,
  output logic              FB_WR,
  input  logic              FB_WAIT,
  output logic              FRAME_DONE,
  output logic              OVERFLOW
);

  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 9;   // {addr, byte, last}

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  logic [XW-1:0]     x_q, x_d, x_b;
  logic [YW-1:0]     y_q, y_d, y_b;
  logic [1:0]        pack_q, pack_d, pack_b;
  logic [5:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] word_q, word_d, word_b;
  logic              push, is_last;
  logic [EW-1:0]     push_entry;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [PW-1:0]     rd_idx, rd_idx_nxt;
  logic [EW-1:0]     head, next_entry;
  logic              empty, full, pop, push_ok, drop;
  logic              ov_q, ov_d;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              fd_q, fd_d;

  // Pixel counting and packing; VSYNC restarts the frame before the pixel
  // of the same cycle is counted, so that pixel lands at (0,0).
  always_comb begin
    x_b        = VSYNC ? '0 : x_q;
    y_b        = VSYNC ? '0 : y_q;
    pack_b     = VSYNC ? '0 : pack_q;
    word_b     = VSYNC ? '0 : word_q;
    x_d        = x_b;
    y_d        = y_b;
    pack_d     = pack_b;
    word_d     = word_b;
    shift_d    = shift_q;
    push       = 1'b0;
    is_last    = 1'b0;
    push_entry = '0;
    if (PX_VALID) begin
      shift_d = {shift_q[3:0], LD};
      pack_d  = pack_b + 2'd1;
      if (x_b == XW'(H_PIXELS - 1)) begin
        x_d = '0;
        y_d = (y_b == YW'(V_LINES - 1)) ? '0 : y_b + YW'(1);
      end else begin
        x_d = x_b + XW'(1);
      end
      if (pack_b == 2'd3) begin
        push       = 1'b1;
        is_last    = (x_b == XW'(H_PIXELS - 1)) && (y_b == YW'(V_LINES - 1));
        push_entry = {ADDR_W'(BASE_ADDR) + word_b, shift_q, LD, is_last};
        // the word counter advances even if the byte is dropped, keeping
        // later addresses aligned with their pixels
        word_d     = is_last ? '0 : word_b + ADDR_W'(1);
      end
    end
  end

  // Pixel-side registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      pack_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      pack_q  <= pack_d;
      shift_q <= shift_d;
      word_q  <= word_d;
    end
  end

  // FIFO status; a push into a full FIFO survives only if the head pops
  // on the same edge.
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    empty      = (count == '0);
    full       = (count == CW'(FIFO_DEPTH));
    rd_idx     = rd_ptr_q[PW-1:0];
    rd_idx_nxt = rd_idx + PW'(1);
    head       = fifo_mem[rd_idx];
    next_entry = fifo_mem[rd_idx_nxt];
    push_ok    = push && (!full || pop);
    drop       = push && full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + CW'(1) : rd_ptr_q;
    ov_d       = VSYNC ? 1'b0 : (ov_q | drop);
  end

  // FIFO storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[PW-1:0]] <= push_entry;
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ov_q     <= ov_d;
    end
  end

  // Writer next-state: load head, hold during wait, pop on acceptance and
  // chain straight into the next entry if one remains.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    fd_d    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          addr_d  = head[EW-1:9];
          data_d  = head[8:1];
          last_d  = head[0];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!FB_WAIT) begin
          pop  = 1'b1;
          fd_d = last_q;
          if (count > CW'(1)) begin
            addr_d = next_entry[EW-1:9];
            data_d = next_entry[8:1];
            last_d = next_entry[0];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writer state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      fd_q    <= fd_d;
    end
  end

  assign FB_WR      = (state_q == S_WRITE);
  assign FB_ADDR    = addr_q;
  assign FB_DATA    = data_q;
  assign FRAME_DONE = fd_q;
  assign OVERFLOW   = ov_q;

endmodule

// File: tb/tb_gb_frame_capture.sv
// Bench for gb_frame_capture: directed scenarios plus random traffic, all
// checked against a pixel-index based reference model with an expected-write
// queue.
module tb_gb_frame_capture;
  localparam int H = 160;
  localparam int V = 144;
  localparam int AW = 13;
  localparam int DEPTH = 8;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst;
  logic PX_VALID, VSYNC, FB_WAIT;
  logic [1:0] LD;
  logic [AW-1:0] FB_ADDR;
  logic [7:0] FB_DATA;
  logic FB_WR, FRAME_DONE, OVERFLOW;

  gb_frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .BASE_ADDR(0),
                     .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PX_VALID(PX_VALID), .LD(LD), .VSYNC(VSYNC),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WR(FB_WR), .FB_WAIT(FB_WAIT),
    .FRAME_DONE(FRAME_DONE), .OVERFLOW(OVERFLOW));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    bit            last;
  } ent_t;

  ent_t exq[$];
  int   pix, npart;
  logic [7:0] part;
  bit   ov_exp, fd_exp, wr_exp;
  int   n_checks, n_errors;
  int   n_writes, n_fd, last_acc_addr;
  logic s_wr;
  logic [AW-1:0] s_addr;
  logic [7:0] s_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exq.delete();
    pix = 0; npart = 0; part = '0;
    ov_exp = 0; fd_exp = 0; wr_exp = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance
  // the reference model, then move to just after the next rising edge.
  task automatic tick(input bit pv, input logic [1:0] ld, input bit vs, input bit wt);
    bit full, acc, fd_nxt, wr_nxt;
    ent_t e;
    PX_VALID = pv; LD = ld; VSYNC = vs; FB_WAIT = wt;
    @(negedge clk);
    s_wr = FB_WR; s_addr = FB_ADDR; s_data = FB_DATA;
    check_val("frame_done", FRAME_DONE, fd_exp);
    check_val("overflow", OVERFLOW, ov_exp);
    check_val("fb_wr", FB_WR, wr_exp);
    if (FRAME_DONE) n_fd++;
    full = (exq.size() == DEPTH);
    acc = 0; fd_nxt = 0;
    if (FB_WR && exq.size() > 0) begin
      check_val("fb_addr", FB_ADDR, exq[0].addr);
      check_val("fb_data", FB_DATA, exq[0].data);
      if (!wt) begin
        acc = 1;
        fd_nxt = exq[0].last;
        last_acc_addr = int'(exq[0].addr);
        void'(exq.pop_front());
        n_writes++;
      end
    end
    if (FB_WR) wr_nxt = wt ? 1'b1 : (exq.size() > 0);
    else       wr_nxt = (exq.size() > 0);
    if (vs) begin pix = 0; npart = 0; ov_exp = 0; end
    if (pv) begin
      part = {part[5:0], ld};
      npart++;
      if (npart == 4) begin
        npart = 0;
        e.addr = AW'(pix / 4);
        e.data = part;
        e.last = (pix == NPIX - 1);
        if (!full || acc) exq.push_back(e);
        else ov_exp = 1;
      end
      pix = (pix + 1) % NPIX;
    end
    fd_exp = fd_nxt;
    wr_exp = wr_nxt;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit wt);
    for (int i = 0; i < n; i++) tick(0, 2'd0, 0, wt);
  endtask

  int w0, f0;
  logic [1:0] seq [4];

  initial begin
    n_checks = 0; n_errors = 0; n_writes = 0; n_fd = 0; last_acc_addr = -1;
    PX_VALID = 0; LD = 0; VSYNC = 0; FB_WAIT = 0; rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_wr", FB_WR, 0);
    check_val("rst_addr", FB_ADDR, 0);
    check_val("rst_data", FB_DATA, 0);
    check_val("rst_fd", FRAME_DONE, 0);
    check_val("rst_ov", OVERFLOW, 0);
    rst = 1;

    // LD 3,2,1,0 -> 0xE4 at address 0, FB_WR exactly one cycle at N+2
    seq[0] = 2'd3; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd0;
    tick(0, 2'd0, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, seq[i], 0, 0);
    tick(0, 2'd0, 0, 0);
    check_val("lat_n1_wr", s_wr, 0);
    tick(0, 2'd0, 0, 0);
    check_val("lat_n2_wr", s_wr, 1);
    check_val("lat_n2_addr", s_addr, 0);
    check_val("lat_n2_data", s_data, 8'hE4);
    tick(0, 2'd0, 0, 0);
    check_val("lat_n3_wr", s_wr, 0);

    // full frame of shade 1, VSYNC coincident with the first pixel
    w0 = n_writes; f0 = n_fd;
    tick(1, 2'd1, 1, 0);
    for (int i = 1; i < NPIX; i++) tick(1, 2'd1, 0, 0);
    idle(6, 0);
    check_val("frame_writes", n_writes - w0, NPIX / 4);
    check_val("frame_done_cnt", n_fd - f0, 1);
    check_val("frame_last_addr", last_acc_addr, NPIX / 4 - 1);
    check_val("frame_ov", OVERFLOW, 0);

    // stall for 40 pixels: 8 bytes queued, 2 dropped, next byte at addr 10
    w0 = n_writes;
    tick(0, 2'd0, 1, 1);
    for (int i = 0; i < 40; i++) tick(1, 2'($urandom_range(0, 3)), 0, 1);
    tick(0, 2'd0, 0, 1);
    check_val("stall_ov", OVERFLOW, 1);
    idle(20, 0);
    check_val("stall_writes", n_writes - w0, 8);
    check_val("stall_last_addr", last_acc_addr, 7);
    for (int i = 0; i < 4; i++) tick(1, 2'($urandom_range(0, 3)), 0, 0);
    idle(4, 0);
    check_val("skip_addr", last_acc_addr, 10);

    // VSYNC after 6 pixels discards the partial pack
    w0 = n_writes;
    tick(0, 2'd0, 1, 0);
    for (int i = 0; i < 6; i++) tick(1, 2'd2, 0, 0);
    idle(4, 0);
    check_val("vs6_addr", last_acc_addr, 0);
    tick(0, 2'd0, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, 2'd3, 0, 0);
    idle(4, 0);
    check_val("vs6_writes", n_writes - w0, 2);
    check_val("vs6_readdr", last_acc_addr, 0);
    check_val("vs6_ov", OVERFLOW, 0);

    // wait pattern 1,1,0 during a write: one acceptance
    w0 = n_writes;
    for (int i = 0; i < 4; i++) tick(1, 2'd1, 0, 0);
    tick(0, 2'd0, 0, 1);
    tick(0, 2'd0, 0, 1);
    tick(0, 2'd0, 0, 1);
    tick(0, 2'd0, 0, 0);
    idle(2, 0);
    check_val("wait_writes", n_writes - w0, 1);

    // async reset while a write is stalled
    tick(0, 2'd0, 1, 1);
    for (int i = 0; i < 4; i++) tick(1, 2'd2, 0, 1);
    idle(2, 1);
    check_val("pre_rst_wr", s_wr, 1);
    #2 rst = 0;
    #1;
    check_val("async_rst_wr", FB_WR, 0);
    check_val("async_rst_addr", FB_ADDR, 0);
    check_val("async_rst_data", FB_DATA, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    for (int i = 0; i < 4; i++) tick(1, 2'd3, 0, 0);
    idle(4, 0);
    check_val("post_rst_addr", last_acc_addr, 0);

    // random traffic
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0);
    for (int i = 0; i < 40 && exq.size() > 0; i++) idle(1, 0);
    idle(2, 0);
    check_val("drain_empty", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
